// File: rtl/cmp_pkg.sv
// Shared result encoding for the registered magnitude comparator.
// Results are packed {eq, gt, lt}; CMP_NONE is the post-reset value.
package cmp_pkg;

  typedef logic [2:0] cmp_res_t;

  localparam cmp_res_t CMP_EQ   = 3'b100;
  localparam cmp_res_t CMP_GT   = 3'b010;
  localparam cmp_res_t CMP_LT   = 3'b001;
  localparam cmp_res_t CMP_NONE = 3'b000;

  // Collapse the cascade's final gt/lt pair into a one-hot result code.
  function automatic cmp_res_t cmp_encode(input logic gt_f, input logic lt_f);
    cmp_res_t res;
    res = CMP_EQ;
    if (gt_f) begin
      res = CMP_GT;
    end else if (lt_f) begin
      res = CMP_LT;
    end
    return res;
  endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// One stage of the MSB-first compare cascade: the first stage that sees
// differing bits latches the decision, later stages pass it through.
module cmp_bit_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic gt_up,
  input  logic lt_up,
  output logic gt_dn_c,
  output logic lt_dn_c
);

  logic decided;

  always_comb begin
    decided = gt_up | lt_up;
    gt_dn_c = gt_up | (~decided & a_i & ~b_i);
    lt_dn_c = lt_up | (~decided & ~a_i & b_i);
  end

endmodule

// File: rtl/mag_comparator.sv
// Registered WIDTH-bit magnitude comparator with one-hot eq/gt/lt flags.
// Define CMP_SIGNED_EN to treat a and b as two's complement operands.
module mag_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int unsigned MSB = WIDTH - 1;

  // chain[WIDTH] feeds the MSB cell; chain[0] is the fully resolved decision.
  logic [WIDTH:0] gt_chain;
  logic [WIDTH:0] lt_chain;

  assign gt_chain[WIDTH] = 1'b0;
  assign lt_chain[WIDTH] = 1'b0;

  for (genvar i = WIDTH; i > 0; i--) begin : g_cascade
    cmp_bit_cell u_cell (
      .a_i     (a[i-1]),
      .b_i     (b[i-1]),
      .gt_up   (gt_chain[i]),
      .lt_up   (lt_chain[i]),
      .gt_dn_c (gt_chain[i-1]),
      .lt_dn_c (lt_chain[i-1])
    );
  end

  logic     gt_fix;
  logic     lt_fix;
  cmp_res_t res_next;

`ifdef CMP_SIGNED_EN
  // With differing sign bits the unsigned verdict is exactly inverted;
  // with equal sign bits the lower bits decide as unsigned.
  logic sign_diff;

  always_comb begin
    sign_diff = a[MSB] ^ b[MSB];
    gt_fix    = sign_diff ? lt_chain[0] : gt_chain[0];
    lt_fix    = sign_diff ? gt_chain[0] : lt_chain[0];
  end
`else
  always_comb begin
    gt_fix = gt_chain[0];
    lt_fix = lt_chain[0];
  end
`endif

  assign res_next = cmp_encode(gt_fix, lt_fix);

  cmp_res_t res_q;

  // Result register: updates only on valid input, holds across bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res_q     <= CMP_NONE;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        res_q <= res_next;
      end
    end
  end

  assign {eq, gt, lt} = res_q;

endmodule

// File: tb/tb_mag_comparator.sv
// Scoreboard bench for mag_comparator: stimulus queues the expected output per
// cycle, a monitor compares one cycle later. Expectations follow CMP_SIGNED_EN.
module tb_mag_comparator;
  import cmp_pkg::*;

  localparam int unsigned WIDTH = 4;
`ifdef CMP_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic             eq;
  logic             gt;
  logic             lt;

  mag_comparator #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .eq        (eq),
    .gt        (gt),
    .lt        (lt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic     valid;
    cmp_res_t res;
    int       tag;
  } exp_t;

  exp_t     sb[$];
  exp_t     mon_e;
  int       errors = 0;
  int       checks = 0;
  cmp_res_t held   = CMP_NONE;
  int       tag_n  = 0;

  // Reference compare written from the arithmetic definition, not the cascade.
  function automatic cmp_res_t golden(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    cmp_res_t r;
    if (SIGNED_BUILD) begin
      if ($signed(x) > $signed(y))      r = CMP_GT;
      else if ($signed(x) < $signed(y)) r = CMP_LT;
      else                              r = CMP_EQ;
    end else begin
      if (x > y)      r = CMP_GT;
      else if (x < y) r = CMP_LT;
      else            r = CMP_EQ;
    end
    return r;
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show after the next edge.
  task automatic drive(input logic rst, input logic v, input logic [WIDTH-1:0] av,
                       input logic [WIDTH-1:0] bv, input cmp_res_t exp_res);
    exp_t e;
    @(negedge clk);
    rst_n    = rst;
    in_valid = v;
    a        = av;
    b        = bv;
    if (!rst)   held = CMP_NONE;
    else if (v) held = exp_res;
    e.valid = rst && v;
    e.res   = held;
    e.tag   = tag_n;
    tag_n++;
    sb.push_back(e);
  endtask

  // Monitor: one pop per clock edge once stimulus has begun.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (out_valid !== mon_e.valid || {eq, gt, lt} !== mon_e.res) begin
        errors++;
        $display("FAIL cmp_vec%0d: got out_valid=%b {eq,gt,lt}=%b, want out_valid=%b {eq,gt,lt}=%b",
                 mon_e.tag, out_valid, {eq, gt, lt}, mon_e.valid, mon_e.res);
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (!$onehot({eq, gt, lt})) begin
          errors++;
          $display("FAIL onehot_vec%0d: got {eq,gt,lt}=%b, want exactly one bit set",
                   mon_e.tag, {eq, gt, lt});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with valid input present: outputs must stay cleared.
    drive(1'b0, 1'b1, 4'd4, 4'd3, CMP_NONE);
    drive(1'b0, 1'b1, 4'd4, 4'd3, CMP_NONE);

    // Back-to-back stream, then a bubble that must hold lt.
    drive(1'b1, 1'b1, 4'd4,  4'd3,  CMP_GT);
    drive(1'b1, 1'b1, 4'd2,  4'd2,  CMP_EQ);
    drive(1'b1, 1'b1, 4'd13, 4'd10, CMP_GT);
    drive(1'b1, 1'b1, 4'd8,  4'd9,  SIGNED_BUILD ? CMP_LT : CMP_LT);
    drive(1'b1, 1'b0, 4'd8,  4'd9,  CMP_NONE);
    drive(1'b1, 1'b0, 4'd1,  4'd0,  CMP_NONE);

    // Extremes.
    drive(1'b1, 1'b1, 4'd0,  4'd0,  CMP_EQ);
    drive(1'b1, 1'b1, 4'd15, 4'd0,  SIGNED_BUILD ? CMP_LT : CMP_GT);
    drive(1'b1, 1'b1, 4'd0,  4'd15, SIGNED_BUILD ? CMP_GT : CMP_LT);
    drive(1'b1, 1'b1, 4'd15, 4'd15, CMP_EQ);

    // Sign-sensitive vectors.
    drive(1'b1, 1'b1, 4'd4,  4'd13, SIGNED_BUILD ? CMP_GT : CMP_LT);
    drive(1'b1, 1'b1, 4'd13, 4'd10, CMP_GT);
    drive(1'b1, 1'b1, 4'd8,  4'd9,  CMP_LT);
    drive(1'b1, 1'b1, 4'd7,  4'd8,  SIGNED_BUILD ? CMP_GT : CMP_LT);
    drive(1'b1, 1'b1, 4'd1,  4'd2,  CMP_LT);

    // Reset mid-stream clears the held result; first valid after it is normal.
    drive(1'b0, 1'b1, 4'd5,  4'd5,  CMP_NONE);
    drive(1'b1, 1'b0, 4'd5,  4'd5,  CMP_NONE);
    drive(1'b1, 1'b1, 4'd6,  4'd5,  CMP_GT);
    drive(1'b1, 1'b0, 4'd0,  4'd9,  CMP_NONE);

    // Exhaustive operand sweep with periodic bubbles.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] ab;
      ab = 8'(i);
      drive(1'b1, 1'((i % 3) != 0), ab[7:4], ab[3:0], golden(ab[7:4], ab[3:0]));
    end

    drive(1'b1, 1'b0, 4'd0, 4'd0, CMP_NONE);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d queued results, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
